// File: rtl/mul_seq_ctrl_if.sv
// Request/result bundle between the EX-stage issue logic and the sequential multiplier.
// Latency: none, pure wiring.
// Backpressure: the busy signal is the stall request back to the pipeline; there is no ready.
interface mul_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic [3:0]       icc_out;

    // Pipeline side: issues operations, observes stall and completion.
    modport master (
        output start, is_signed, op_a, op_b, flush,
        input  busy, done, result_hi, result_lo, icc_out
    );

    // Multiplier side.
    modport slave (
        input  start, is_signed, op_a, op_b, flush,
        output busy, done, result_hi, result_lo, icc_out
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Radix-2 shift-add sequencer for SPARC UMUL/SMUL(cc): sign-magnitude iterate, sign-fix, Y:rd + icc.
// Latency: done pulses in the cycle after edge E0+WIDTH+1; one op per WIDTH+3 cycles.
// Backpressure: busy stalls the pipeline in RUN/FIX; start outside IDLE is dropped, never queued.
module mul_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    mul_seq_ctrl_if.slave io_mul
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_count;
    logic               r_sign_neg;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    // One bit wider than the operands so the add carry survives until the shift.
    logic [WIDTH:0]     r_acc;
    logic [WIDTH-1:0]   r_res_hi;
    logic [WIDTH-1:0]   r_res_lo;
    logic [3:0]         r_icc;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;

    // A flush in the same cycle as start cancels the request outright.
    assign w_accept = io_mul.start & ~io_mul.flush;
    assign w_last   = (r_count == CW'(WIDTH - 1));

    // Operands are iterated as magnitudes; 0x80..0 negates to itself, which is the right magnitude.
    assign w_mag_a = (io_mul.is_signed && io_mul.op_a[WIDTH-1]) ? -io_mul.op_a : io_mul.op_a;
    assign w_mag_b = (io_mul.is_signed && io_mul.op_b[WIDTH-1]) ? -io_mul.op_b : io_mul.op_b;

    // Upper accumulator plus multiplicand when the current multiplier bit is set.
    assign w_sum = r_acc + (r_mplr[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});

    // After WIDTH steps the accumulator top bit is always clear, so the low W bits are the high word.
    assign w_prod_mag = {r_acc[WIDTH-1:0], r_mplr};
    assign w_prod     = r_sign_neg ? -w_prod_mag : w_prod_mag;

    assign io_mul.busy      = (r_state == S_RUN) || (r_state == S_FIX);
    assign io_mul.done      = (r_state == S_DONE);
    assign io_mul.result_hi = r_res_hi;
    assign io_mul.result_lo = r_res_lo;
    assign io_mul.icc_out   = r_icc;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: flush aborts RUN/FIX, but a DONE pulse always completes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN: begin
                if (io_mul.flush)  w_state_nxt = S_IDLE;
                else if (w_last)   w_state_nxt = S_FIX;
            end
            S_FIX:   w_state_nxt = io_mul.flush ? S_IDLE : S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch on accept, shift-add in RUN, sign-fix and publish results at the FIX edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_sign_neg <= 1'b0;
            r_mcand    <= '0;
            r_mplr     <= '0;
            r_acc      <= '0;
            r_res_hi   <= '0;
            r_res_lo   <= '0;
            r_icc      <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign_neg <= io_mul.is_signed & (io_mul.op_a[WIDTH-1] ^ io_mul.op_b[WIDTH-1]);
                        r_mcand    <= w_mag_a;
                        r_mplr     <= w_mag_b;
                        r_acc      <= '0;
                        r_count    <= '0;
                    end
                end
                S_RUN: begin
                    // Shift {sum, multiplier} right by one; the sum LSB moves into the multiplier MSB.
                    r_acc   <= {1'b0, w_sum[WIDTH:1]};
                    r_mplr  <= {w_sum[0], r_mplr[WIDTH-1:1]};
                    r_count <= r_count + CW'(1);
                end
                S_FIX: begin
                    if (!io_mul.flush) begin
                        r_res_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_res_lo <= w_prod[WIDTH-1:0];
                        // Multiply cc: N and Z from the low word only, V and C always clear.
                        r_icc    <= {w_prod[WIDTH-1], (w_prod[WIDTH-1:0] == '0), 2'b00};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed vector table, corner sequences, random vs reference.
// Latency: checks done at E0+33 and a 33-cycle busy window.
// Backpressure: exercises start-while-busy, start-in-DONE, flush and mid-op reset.
module tb_mul_seq_ctrl;
    localparam int W = 32;

    logic clk;
    logic rst_n;

    mul_seq_ctrl_if #(.WIDTH(W)) mif ();

    mul_seq_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_mul (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Last result the bench expects the outputs to hold.
    logic [W-1:0] prev_hi, prev_lo;
    logic [3:0]   prev_icc;

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [3:0]   icc;
    } vec_t;

    vec_t         vecs[10];
    logic [W-1:0] corners[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the operands as the ISA defines them.
    function automatic logic [63:0] ref_prod(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint pa, pb;
        pa = s ? longint'($signed(a)) : longint'({32'b0, a});
        pb = s ? longint'($signed(b)) : longint'({32'b0, b});
        return 64'(pa * pb);
    endfunction

    function automatic logic [3:0] ref_icc(input logic [63:0] p);
        return {p[31], (p[31:0] == 32'd0), 2'b00};
    endfunction

    // Issue one op, then check latency, busy window, results and the one-cycle done pulse.
    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic [3:0] eicc,
                          input string tag);
        int   n;
        int   busy_c;
        logic seen;
        @(negedge clk);
        mif.is_signed = s;
        mif.op_a      = a;
        mif.op_b      = b;
        mif.start     = 1'b1;
        @(posedge clk);
        #1;
        mif.start     = 1'b0;
        // Operands scrambled after E0 must not matter.
        mif.op_a      = $urandom;
        mif.op_b      = $urandom;
        mif.is_signed = 1'($urandom_range(0, 1));
        @(negedge clk);
        busy_c = mif.busy ? 1 : 0;
        seen   = 1'b0;
        n      = 0;
        while (!seen && n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (mif.busy) busy_c++;
            if (mif.done) seen = 1'b1;
        end
        chk($sformatf("%s.latency", tag), 64'(n), 64'(W + 1));
        chk($sformatf("%s.busy_cycles", tag), 64'(busy_c), 64'(W + 1));
        chk($sformatf("%s.hi", tag), 64'(mif.result_hi), 64'(ehi));
        chk($sformatf("%s.lo", tag), 64'(mif.result_lo), 64'(elo));
        chk($sformatf("%s.icc", tag), 64'(mif.icc_out), 64'(eicc));
        @(negedge clk);
        chk($sformatf("%s.done_width", tag), 64'(mif.done), 64'(0));
        prev_hi  = ehi;
        prev_lo  = elo;
        prev_icc = eicc;
    endtask

    // Watch for done over a window where none must appear; also require results unchanged.
    task automatic quiet_window(input int cycles, input string tag);
        int d;
        d = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (mif.done) d++;
        end
        chk($sformatf("%s.no_done", tag), 64'(d), 64'(0));
        chk($sformatf("%s.hi_kept", tag), 64'(mif.result_hi), 64'(prev_hi));
        chk($sformatf("%s.lo_kept", tag), 64'(mif.result_lo), 64'(prev_lo));
        chk($sformatf("%s.icc_kept", tag), 64'(mif.icc_out), 64'(prev_icc));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 32'd7,         32'd6,         32'h00000000, 32'h0000002A, 4'b0000};
        vecs[1] = '{1'b1, 32'hFFFFFFFD,  32'd5,         32'hFFFFFFFF, 32'hFFFFFFF1, 4'b1000};
        vecs[2] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 32'h00000001, 4'b0000};
        vecs[3] = '{1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000, 32'h00000001, 4'b0000};
        vecs[4] = '{1'b1, 32'h80000000,  32'h80000000,  32'h40000000, 32'h00000000, 4'b0100};
        vecs[5] = '{1'b0, 32'h00010000,  32'h00010000,  32'h00000001, 32'h00000000, 4'b0100};
        vecs[6] = '{1'b1, 32'h7FFFFFFF,  32'h80000000,  32'hC0000000, 32'h80000000, 4'b1000};
        vecs[7] = '{1'b1, 32'h80000000,  32'd1,         32'hFFFFFFFF, 32'h80000000, 4'b1000};
        vecs[8] = '{1'b1, 32'd0,         32'hFFFFFFFF,  32'h00000000, 32'h00000000, 4'b0100};
        vecs[9] = '{1'b0, 32'h80000000,  32'd2,         32'h00000001, 32'h00000000, 4'b0100};
        corners[0] = 32'h00000000;
        corners[1] = 32'h00000001;
        corners[2] = 32'hFFFFFFFF;
        corners[3] = 32'h80000000;
        corners[4] = 32'h7FFFFFFF;

        rst_n         = 1'b0;
        mif.start     = 1'b0;
        mif.flush     = 1'b0;
        mif.is_signed = 1'b0;
        mif.op_a      = '0;
        mif.op_b      = '0;
        prev_hi       = '0;
        prev_lo       = '0;
        prev_icc      = '0;

        // Reset state.
        #3;
        chk("reset.busy", 64'(mif.busy), 64'(0));
        chk("reset.done", 64'(mif.done), 64'(0));
        chk("reset.hi",   64'(mif.result_hi), 64'(0));
        chk("reset.lo",   64'(mif.result_lo), 64'(0));
        chk("reset.icc",  64'(mif.icc_out), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].icc,
                   $sformatf("vec%0d", i));
        end

        // Flush in RUN: abort, no done, previous results kept; then a clean 2*3.
        @(negedge clk);
        mif.is_signed = 1'b0;
        mif.op_a      = 32'd9;
        mif.op_b      = 32'd9;
        mif.start     = 1'b1;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("flush.busy_before", 64'(mif.busy), 64'(1));
        mif.flush = 1'b1;
        @(posedge clk);
        #1;
        mif.flush = 1'b0;
        @(negedge clk);
        chk("flush.busy_after", 64'(mif.busy), 64'(0));
        quiet_window(40, "flush");
        run_op(1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 4'b0000, "after_flush");

        // Flush together with start in IDLE: nothing starts.
        @(negedge clk);
        mif.op_a  = 32'd5;
        mif.op_b  = 32'd5;
        mif.start = 1'b1;
        mif.flush = 1'b1;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        mif.flush = 1'b0;
        @(negedge clk);
        chk("idle_flush.busy", 64'(mif.busy), 64'(0));
        quiet_window(40, "idle_flush");

        // start held high through RUN with new operands: first op's result returned.
        begin
            int   n;
            logic seen;
            @(negedge clk);
            mif.is_signed = 1'b0;
            mif.op_a      = 32'd5;
            mif.op_b      = 32'd5;
            mif.start     = 1'b1;
            @(posedge clk);
            #1;
            mif.op_a = 32'd100;
            mif.op_b = 32'd100;
            n    = 0;
            seen = 1'b0;
            while (!seen && n < 60) begin
                @(posedge clk);
                n++;
                @(negedge clk);
                if (mif.done) seen = 1'b1;
            end
            chk("hold.latency", 64'(n), 64'(W + 1));
            chk("hold.hi", 64'(mif.result_hi), 64'(0));
            chk("hold.lo", 64'(mif.result_lo), 64'(25));
            // start still high in DONE: must not launch a new op.
            @(posedge clk);
            #1;
            mif.start = 1'b0;
            @(negedge clk);
            chk("hold.no_restart", 64'(mif.busy), 64'(0));
            prev_hi  = 32'd0;
            prev_lo  = 32'd25;
            prev_icc = 4'b0000;
        end

        // Reset mid-operation: outputs clear asynchronously, no done afterwards.
        @(negedge clk);
        mif.op_a  = 32'd7;
        mif.op_b  = 32'd7;
        mif.start = 1'b1;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        repeat (18) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", 64'(mif.busy), 64'(0));
        chk("midrst.done", 64'(mif.done), 64'(0));
        chk("midrst.hi",   64'(mif.result_hi), 64'(0));
        chk("midrst.lo",   64'(mif.result_lo), 64'(0));
        chk("midrst.icc",  64'(mif.icc_out), 64'(0));
        @(negedge clk);
        rst_n    = 1'b1;
        prev_hi  = '0;
        prev_lo  = '0;
        prev_icc = '0;
        quiet_window(40, "midrst");

        // Random operations against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            logic         s;
            logic [W-1:0] a, b;
            logic [63:0]  p;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = corners[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) b = corners[$urandom_range(0, 4)];
            p = ref_prod(s, a, b);
            run_op(s, a, b, p[63:32], p[31:0], ref_icc(p), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
